// File: rtl/bus_owner_arbiter.sv
// Round-robin owner sequencer for the shared internal data bus: registered one-hot
// output enables, a turnaround gap between owners and hold-time pre-emption.
module bus_owner_arbiter #(
    parameter int N           = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         iReq,
    output logic [N-1:0]         oGrant,
    output logic [$clog2(N)-1:0] oOwner,
    output logic                 oBusy,
    output logic                 oPreempt
);
    localparam int         OW        = $clog2(N);
    localparam int         CW        = OW + 1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [OW-1:0] ptr, ptr_n;
    logic [7:0]    hold, hold_n;
    logic [1:0]    turn, turn_n;
    logic [N-1:0]  grant_n;
    logic [OW-1:0] owner_n;
    logic          preempt_n;

    logic          win_found;
    logic [OW-1:0] win;
    logic [OW-1:0] win_next;
    logic [CW-1:0] cand;
    logic          owner_req;
    logic          others_req;

    // Rotating priority: first requester at or above ptr, wrapping modulo N.
    // NOTE: combinational blocks use blocking '=' so later lines see the values just computed.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N)) cand = cand - CW'(N);
            if (!win_found && iReq[cand[OW-1:0]]) begin
                win_found = 1'b1;
                win       = cand[OW-1:0];
            end
        end
    end

    assign win_next   = (win == OW'(N - 1)) ? '0 : win + 1'b1;
    assign owner_req  = |(iReq & oGrant);
    assign others_req = |(iReq & ~oGrant);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold;
        turn_n    = turn;
        grant_n   = oGrant;
        owner_n   = oOwner;
        preempt_n = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_n = N'(1) << win;
                    owner_n = win;
                    ptr_n   = win_next;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    grant_n = '0;
                    turn_n  = '0;
                    state_n = TURN;
                end else if (hold == HOLD_LAST && others_req) begin
                    grant_n   = '0;
                    preempt_n = 1'b1;
                    turn_n    = '0;
                    state_n   = TURN;
                end else if (hold != HOLD_LAST) begin
                    hold_n = hold + 8'd1;
                end
            end
            TURN: begin
                if (turn == TURN_LAST) begin
                    if (win_found) begin
                        grant_n = N'(1) << win;
                        owner_n = win;
                        ptr_n   = win_next;
                        hold_n  = '0;
                        state_n = GRANT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    turn_n = turn + 2'd1;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered together with the state so oBusy always tracks oGrant.
    // NOTE: clocked state uses non-blocking '<=' so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold     <= '0;
            turn     <= '0;
            oGrant   <= '0;
            oOwner   <= '0;
            oBusy    <= 1'b0;
            oPreempt <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold     <= hold_n;
            turn     <= turn_n;
            oGrant   <= grant_n;
            oOwner   <= owner_n;
            oBusy    <= |grant_n;
            oPreempt <= preempt_n;
        end
    end
endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Self-checking bench for bus_owner_arbiter: directed scenarios with literal expectations
// plus a cycle-by-cycle comparison against a behavioural ownership model.
module tb_bus_owner_arbiter;
    localparam int N            = 4;
    localparam int MAX_HOLD     = 8;
    localparam int TURN_CYCLES  = 1;
    localparam int RAND_CYCLES  = 3000;
    localparam int STARVE_LIMIT = N * (MAX_HOLD + TURN_CYCLES + 1);

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b0;
    logic [N-1:0]         iReq = '0;
    logic [N-1:0]         oGrant;
    logic [$clog2(N)-1:0] oOwner;
    logic                 oBusy;
    logic                 oPreempt;

    int n_checks = 0;
    int n_errors = 0;

    bus_owner_arbiter #(
        .N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .iReq(iReq),
        .oGrant(oGrant), .oOwner(oOwner), .oBusy(oBusy), .oPreempt(oPreempt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are read there too.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: who owns the bus, how long it has held it, how many
    // idle gap cycles remain, and where the next round-robin search starts.
    bit           m_has   = 1'b0;
    int           m_owner = 0;
    int           m_held  = 0;
    int           m_gap   = 0;
    int           m_next  = 0;
    bit           m_pre   = 1'b0;
    logic [N-1:0] m_others;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_has = 1'b0; m_owner = 0; m_held = 0; m_gap = 0; m_next = 0; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_has) begin
                m_others = iReq;
                m_others[m_owner] = 1'b0;
                if (!iReq[m_owner]) begin
                    m_has = 1'b0;
                    m_gap = TURN_CYCLES;
                end else if (m_held >= MAX_HOLD && m_others != 0) begin
                    m_has = 1'b0;
                    m_gap = TURN_CYCLES;
                    m_pre = 1'b1;
                end else if (m_held < MAX_HOLD) begin
                    m_held++;
                end
            end else if (m_gap > 1) begin
                m_gap--;
            end else begin
                m_gap = 0;
                for (int k = 0; k < N; k++) begin
                    if (!m_has && iReq[(m_next + k) % N]) begin
                        m_has   = 1'b1;
                        m_owner = (m_next + k) % N;
                        m_held  = 1;
                        m_next  = (m_owner + 1) % N;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus bus-safety invariants.
    logic [N-1:0] exp_grant;
    logic [N-1:0] prev_grant = '0;
    int           zero_run   = 0;
    bit           seen_nz    = 1'b0;
    int           wait_cnt[N];
    int           max_wait   = 0;

    initial foreach (wait_cnt[i]) wait_cnt[i] = 0;

    always @(negedge clk) begin
        exp_grant = m_has ? (N'(1) << m_owner) : '0;
        check("model_grant",   32'(oGrant),   32'(exp_grant));
        check("model_owner",   32'(oOwner),   32'(m_owner));
        check("model_busy",    32'(oBusy),    32'(m_has));
        check("model_preempt", 32'(oPreempt), 32'(m_pre));
        check("grant_onehot",  32'($countones(oGrant) <= 1), 32'd1);
        if (oGrant != 0) begin
            if (prev_grant != 0)
                check("no_direct_handover", 32'(oGrant), 32'(prev_grant));
            else if (seen_nz)
                check("turnaround_gap", 32'(zero_run >= TURN_CYCLES), 32'd1);
            seen_nz  = 1'b1;
            zero_run = 0;
        end else begin
            zero_run++;
        end
        prev_grant = oGrant;
        for (int i = 0; i < N; i++) begin
            if (rst && iReq[i] && !oGrant[i]) begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end else begin
                wait_cnt[i] = 0;
            end
        end
    end

    task automatic pulse_reset();
        rst  = 1'b0;
        iReq = '0;
        tick();
        rst  = 1'b1;
    endtask

    initial begin
        // Reset held with every source requesting: nothing may be granted.
        rst  = 1'b0;
        iReq = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_grant",   32'(oGrant),   32'h0);
            check("rst_busy",    32'(oBusy),    32'h0);
            check("rst_owner",   32'(oOwner),   32'h0);
            check("rst_preempt", 32'(oPreempt), 32'h0);
        end
        iReq = '0;
        rst  = 1'b1;
        tick();

        // Single requester for five cycles.
        iReq = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("single_grant", 32'(oGrant), 32'h4);
            check("single_owner", 32'(oOwner), 32'd2);
        end
        iReq = '0;
        tick();
        check("single_release", 32'(oGrant), 32'h0);
        check("single_release_busy", 32'(oBusy), 32'h0);
        tick();
        check("single_idle", 32'(oGrant), 32'h0);
        check("single_idle_owner", 32'(oOwner), 32'd2);

        // Everyone requesting: 0,1,2,3,0, each pre-empted after MAX_HOLD cycles.
        pulse_reset();
        iReq = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                tick();
                check("rr_grant", 32'(oGrant), 32'(1 << (g % N)));
                check("rr_no_preempt", 32'(oPreempt), 32'h0);
            end
            tick();
            check("rr_gap", 32'(oGrant), 32'h0);
            check("rr_preempt_pulse", 32'(oPreempt), 32'h1);
        end
        iReq = '0;
        tick();
        tick();

        // Early release with a waiting competitor: gap, then source 3, no pre-empt.
        pulse_reset();
        iReq = 4'b0010;
        tick();
        check("early_grant1", 32'(oGrant), 32'h2);
        iReq = 4'b1010;
        tick();
        check("early_grant2", 32'(oGrant), 32'h2);
        tick();
        check("early_grant3", 32'(oGrant), 32'h2);
        iReq = 4'b1000;
        tick();
        check("early_gap", 32'(oGrant), 32'h0);
        check("early_gap_preempt", 32'(oPreempt), 32'h0);
        tick();
        check("early_next", 32'(oGrant), 32'h8);
        check("early_next_owner", 32'(oOwner), 32'd3);
        check("early_next_preempt", 32'(oPreempt), 32'h0);
        iReq = '0;
        tick();
        tick();

        // Lone requester holds indefinitely; a newcomer pre-empts at once after saturation.
        pulse_reset();
        iReq = 4'b0001;
        for (int c = 0; c < 20; c++) tick();
        check("lone_grant", 32'(oGrant), 32'h1);
        check("lone_preempt", 32'(oPreempt), 32'h0);
        iReq = 4'b0011;
        tick();
        check("late_preempt_gap", 32'(oGrant), 32'h0);
        check("late_preempt_pulse", 32'(oPreempt), 32'h1);
        tick();
        check("late_preempt_next", 32'(oGrant), 32'h2);
        iReq = '0;
        tick();
        tick();

        // Asynchronous reset between edges while source 2 owns the bus.
        iReq = 4'b0100;
        tick();
        check("midrst_grant", 32'(oGrant), 32'h4);
        #1 rst = 1'b0;
        #1;
        check("midrst_async_grant",   32'(oGrant),   32'h0);
        check("midrst_async_busy",    32'(oBusy),    32'h0);
        check("midrst_async_preempt", 32'(oPreempt), 32'h0);
        tick();
        rst  = 1'b1;
        iReq = 4'b0101;
        tick();
        check("midrst_ptr_grant", 32'(oGrant), 32'h1);
        check("midrst_ptr_owner", 32'(oOwner), 32'd0);
        iReq = '0;
        tick();
        tick();

        // Random request churn, checked cycle by cycle against the model.
        for (int c = 0; c < RAND_CYCLES; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) iReq[i] = ~iReq[i];
            tick();
        end
        iReq = '0;
        for (int c = 0; c < 4; c++) tick();
        check("starvation_bound", 32'(max_wait <= STARVE_LIMIT), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
